// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard scoreboard signal bundle
interface hazard_scoreboard_if;
   logic        id_valid;
   logic [2:0]  id_ra;
   logic [2:0]  id_rb;
   logic        id_use_a;
   logic        id_use_b;
   logic [2:0]  id_rd;
   logic        id_regwrite;
   logic        id_is_load;
   logic        flush;
   logic        stall;
   logic        issue;
   logic [7:0]  busy;
   logic [15:0] stall_cycles;

   modport master (
      output id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rd, id_regwrite, id_is_load, flush,
      input  stall, issue, busy, stall_cycles
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rd, id_regwrite, id_is_load, flush,
      output stall, issue, busy, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-latency scoreboard with flush rollback
module hazard_scoreboard #(
   parameter int LOAD_LAT = 1,
   parameter int ALU_LAT  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_scoreboard_if.slave sb
);
   localparam logic [1:0] LD_LAT = 2'(LOAD_LAT);
   localparam logic [1:0] AL_LAT = 2'(ALU_LAT);

   logic [7:0][1:0] r_cnt;
   logic            r_ex_valid;
   logic [2:0]      r_ex_rd;
   logic            r_ex_wr;
   logic [1:0]      r_ex_prev;
   logic [15:0]     r_stall_cycles;

   logic            w_hit_a;
   logic            w_hit_b;
   logic            w_stall;
   logic            w_issue;
   logic            w_restore;
   logic [7:0]      w_busy;

   function automatic logic [1:0] sat_dec(input logic [1:0] v);
      return (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

   assign w_hit_a   = sb.id_use_a && (r_cnt[sb.id_ra] != 2'd0);
   assign w_hit_b   = sb.id_use_b && (r_cnt[sb.id_rb] != 2'd0);
   assign w_stall   = rst_n && sb.id_valid && !sb.flush && (w_hit_a || w_hit_b);
   assign w_issue   = rst_n && sb.id_valid && !sb.flush && !w_stall;
   // A flushed writer hands its register back to the older writer's remaining obligation.
   assign w_restore = sb.flush && r_ex_valid && r_ex_wr;

   always_comb begin
      w_busy = '0;
      for (int n = 0; n < 8; n++) begin
         w_busy[n] = (r_cnt[n] != 2'd0);
      end
   end

   assign sb.stall        = w_stall;
   assign sb.issue        = w_issue;
   assign sb.busy         = w_busy;
   assign sb.stall_cycles = r_stall_cycles;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt          <= '0;
         r_ex_valid     <= 1'b0;
         r_ex_rd        <= 3'd0;
         r_ex_wr        <= 1'b0;
         r_ex_prev      <= 2'd0;
         r_stall_cycles <= 16'd0;
      end else begin
         for (int n = 0; n < 8; n++) begin
            r_cnt[n] <= sat_dec(r_cnt[n]);
         end
         if (w_restore) begin
            r_cnt[r_ex_rd] <= sat_dec(r_ex_prev);
         end
         if (w_issue && sb.id_regwrite) begin
            r_cnt[sb.id_rd] <= sb.id_is_load ? LD_LAT : AL_LAT;
         end

         r_ex_valid <= w_issue;
         if (w_issue) begin
            r_ex_rd   <= sb.id_rd;
            r_ex_wr   <= sb.id_regwrite;
            r_ex_prev <= sat_dec(r_cnt[sb.id_rd]);
         end

         if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   hazard_scoreboard_if a_if ();
   hazard_scoreboard_if b_if ();

   hazard_scoreboard u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (a_if.slave)
   );

   hazard_scoreboard #(.LOAD_LAT(3), .ALU_LAT(0)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic [2:0] ra, input logic ua, input logic [2:0] rb,
                        input logic ub, input logic [2:0] rd, input logic rw, input logic ld,
                        input logic fl);
      a_if.id_valid = v;  a_if.id_ra = ra; a_if.id_use_a = ua; a_if.id_rb = rb;
      a_if.id_use_b = ub; a_if.id_rd = rd; a_if.id_regwrite = rw; a_if.id_is_load = ld;
      a_if.flush = fl;
      #2;
   endtask

   task automatic drv_b(input logic v, input logic [2:0] ra, input logic ua, input logic [2:0] rb,
                        input logic ub, input logic [2:0] rd, input logic rw, input logic ld,
                        input logic fl);
      b_if.id_valid = v;  b_if.id_ra = ra; b_if.id_use_a = ua; b_if.id_rb = rb;
      b_if.id_use_b = ub; b_if.id_rd = rd; b_if.id_regwrite = rw; b_if.id_is_load = ld;
      b_if.flush = fl;
      #2;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drv_a(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 1, 0);
      drv_b(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 1, 0);
      tick;
      tick;
      checks++;
      if (a_if.issue !== 1'b0 || a_if.stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs a issue=%b stall=%b expected 0 0", a_if.issue, a_if.stall);
      end
      checks++;
      if (a_if.busy !== 8'h00 || b_if.busy !== 8'h00) begin
         errors++;
         $display("FAIL reset_busy a=%h b=%h expected 00", a_if.busy, b_if.busy);
      end
      checks++;
      if (a_if.stall_cycles !== 16'd0 || b_if.stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_sc a=%0d b=%0d expected 0", a_if.stall_cycles, b_if.stall_cycles);
      end
      drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   task automatic test_load_use;
      tick;
      drv_a(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0);
      checks++;
      if (a_if.issue !== 1'b1) begin
         errors++;
         $display("FAIL load_issue got %b expected 1", a_if.issue);
      end
      tick;
      drv_a(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
      checks++;
      if (a_if.stall !== 1'b1 || a_if.issue !== 1'b0 || a_if.busy !== 8'h08) begin
         errors++;
         $display("FAIL load_use_stall stall=%b issue=%b busy=%h expected 1 0 08",
                  a_if.stall, a_if.issue, a_if.busy);
      end
      tick;
      drv_a(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
      checks++;
      if (a_if.stall !== 1'b0 || a_if.issue !== 1'b1 || a_if.busy !== 8'h00 ||
          a_if.stall_cycles !== 16'd1) begin
         errors++;
         $display("FAIL load_use_release stall=%b issue=%b busy=%h sc=%0d expected 0 1 00 1",
                  a_if.stall, a_if.issue, a_if.busy, a_if.stall_cycles);
      end
   endtask

   task automatic test_alu_forward;
      tick;
      drv_a(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0);
      tick;
      drv_a(1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 0, 0);
      checks++;
      if (a_if.stall !== 1'b0 || a_if.issue !== 1'b1 || a_if.busy !== 8'h00) begin
         errors++;
         $display("FAIL alu_no_stall stall=%b issue=%b busy=%h expected 0 1 00",
                  a_if.stall, a_if.issue, a_if.busy);
      end
   endtask

   task automatic test_same_reg;
      tick;
      drv_a(1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 1, 0);
      tick;
      drv_a(1, 3'd7, 1, 3'd7, 1, 3'd0, 0, 0, 0);
      checks++;
      if (a_if.stall !== 1'b1 || a_if.busy !== 8'h80) begin
         errors++;
         $display("FAIL same_reg_stall stall=%b busy=%h expected 1 80", a_if.stall, a_if.busy);
      end
      tick;
      drv_a(1, 3'd7, 1, 3'd7, 1, 3'd0, 0, 0, 0);
      checks++;
      if (a_if.issue !== 1'b1 || a_if.stall_cycles !== 16'd2) begin
         errors++;
         $display("FAIL same_reg_once issue=%b sc=%0d expected 1 2", a_if.issue, a_if.stall_cycles);
      end
   endtask

   task automatic test_flush_squash;
      tick;
      drv_a(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0);
      tick;
      drv_a(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 1);
      checks++;
      if (a_if.stall !== 1'b0 || a_if.issue !== 1'b0) begin
         errors++;
         $display("FAIL flush_squash stall=%b issue=%b expected 0 0", a_if.stall, a_if.issue);
      end
      tick;
      drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (a_if.busy !== 8'h00) begin
         errors++;
         $display("FAIL flush_busy got %h expected 00", a_if.busy);
      end
   endtask

   task automatic test_long_load;
      logic [2:0] exp_busy2;
      tick;
      drv_b(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick;
         drv_b(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0, 0);
         exp_busy2 = 3'b111;
         checks++;
         if (b_if.busy[2] !== exp_busy2[0] && i < 3 || b_if.stall !== (i < 3)) begin
            errors++;
            $display("FAIL long_load_c%0d busy2=%b stall=%b expected %b %b",
                     i, b_if.busy[2], b_if.stall, (i < 3), (i < 3));
         end
         if (i == 3) begin
            checks++;
            if (b_if.busy[2] !== 1'b0 || b_if.issue !== 1'b1) begin
               errors++;
               $display("FAIL long_load_rel busy2=%b issue=%b expected 0 1", b_if.busy[2], b_if.issue);
            end
         end
      end
      checks++;
      if (b_if.stall_cycles !== 16'd3) begin
         errors++;
         $display("FAIL long_load_sc got %0d expected 3", b_if.stall_cycles);
      end
   endtask

   task automatic test_flush_restore;
      tick;
      drv_b(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1, 0);
      tick;
      drv_b(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0);
      checks++;
      if (b_if.issue !== 1'b1 || b_if.busy[4] !== 1'b1) begin
         errors++;
         $display("FAIL restore_alu issue=%b busy4=%b expected 1 1", b_if.issue, b_if.busy[4]);
      end
      tick;
      drv_b(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (b_if.busy[4] !== 1'b0) begin
         errors++;
         $display("FAIL restore_pre busy4=%b expected 0", b_if.busy[4]);
      end
      tick;
      drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (b_if.busy[4] !== 1'b1) begin
         errors++;
         $display("FAIL restore_post busy4=%b expected 1", b_if.busy[4]);
      end
      tick;
      checks++;
      if (b_if.busy[4] !== 1'b0) begin
         errors++;
         $display("FAIL restore_drain busy4=%b expected 0", b_if.busy[4]);
      end
   endtask

   task automatic test_reset_mid_stall;
      tick;
      drv_b(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1, 0);
      tick;
      drv_b(1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 0, 0);
      tick;
      drv_b(1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 0, 0);
      checks++;
      if (b_if.stall !== 1'b1 || b_if.busy !== 8'h40) begin
         errors++;
         $display("FAIL mid_stall stall=%b busy=%h expected 1 40", b_if.stall, b_if.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (b_if.stall !== 1'b0 || b_if.issue !== 1'b0) begin
         errors++;
         $display("FAIL rst_comb stall=%b issue=%b expected 0 0", b_if.stall, b_if.issue);
      end
      tick;
      checks++;
      if (b_if.busy !== 8'h00 || b_if.stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid busy=%h sc=%0d expected 00 0", b_if.busy, b_if.stall_cycles);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (b_if.issue !== 1'b1 || b_if.stall !== 1'b0) begin
         errors++;
         $display("FAIL rst_release issue=%b stall=%b expected 1 0", b_if.issue, b_if.stall);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      test_reset;
      test_load_use;
      test_alu_forward;
      test_same_reg;
      test_flush_squash;
      test_long_load;
      test_flush_restore;
      test_reset_mid_stall;
      tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
